// File: rtl/prog_cntr_seq_pkg.sv
// Shared definitions for the program-counter sequencer: op-code encodings
// used by the next-pc decode and by anything upstream that drives op.
package prog_cntr_seq_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_INC    = 3'd0;
    localparam logic [OP_W-1:0] OP_JUMP   = 3'd1;
    localparam logic [OP_W-1:0] OP_BRANCH = 3'd2;
    localparam logic [OP_W-1:0] OP_CALL   = 3'd3;
    localparam logic [OP_W-1:0] OP_RET    = 3'd4;

    // True for the five defined op codes; 5..7 are illegal.
    function automatic logic op_is_legal(input logic [OP_W-1:0] op_in);
        return (op_in <= OP_RET);
    endfunction

endpackage

// File: rtl/prog_cntr_seq_ret_stack.sv
// Return-address LIFO. A push when full or a pop when empty is silently
// refused here; the caller decides what fault to raise. Top, depth, full and
// empty are combinational from the registers so they show post-edge state.
module ret_stack
    import prog_cntr_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [WIDTH-1:0]             i_data,
    output logic [WIDTH-1:0]             o_top,
    output logic [$clog2(DEPTH+1)-1:0]   o_depth,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DW-1:0]    r_cnt;

    logic          w_full;
    logic          w_empty;
    logic          w_do_push;
    logic          w_do_pop;
    logic [IW-1:0] w_wr_idx;
    logic [IW-1:0] w_rd_idx;

    assign w_full    = (r_cnt == DW'(DEPTH));
    assign w_empty   = (r_cnt == '0);
    // Push wins if both are requested; the top level never asks for both.
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !i_push && !w_empty;
    // Next free slot equals the count; it always fits IW bits when not full.
    assign w_wr_idx  = r_cnt[IW-1:0];
    assign w_rd_idx  = IW'(r_cnt - 1'b1);

    // Entry storage: all entries zeroed on reset, one slot written per push.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

    // Occupancy counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_do_push) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (w_do_pop) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_top   = w_empty ? '0 : r_mem[w_rd_idx];
    assign o_depth = r_cnt;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/prog_cntr_seq.sv
// Program-counter sequencer for the fetch stage. Holds the fetch address,
// selects the next one from step/jump/branch/call/return, keeps a return
// stack and sticky fault flags for stack misuse and illegal op codes.
module prog_cntr_seq
    import prog_cntr_seq_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter int               STEP       = 1,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0,
    parameter int               DEPTH      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [2:0]                  op,
    input  logic [WIDTH-1:0]            target,
    input  logic [WIDTH-1:0]            offset,
    output logic [WIDTH-1:0]            pc,
    output logic [WIDTH-1:0]            ret_top,
    output logic [$clog2(DEPTH+1)-1:0]  depth,
    output logic                        stk_full,
    output logic                        stk_empty,
    output logic                        err_ovf,
    output logic                        err_unf,
    output logic                        err_ill
);

    logic [WIDTH-1:0] r_pc;
    logic             r_err_ovf;
    logic             r_err_unf;
    logic             r_err_ill;

    logic [WIDTH-1:0] w_pc_step;
    logic [WIDTH-1:0] w_pc_branch;
    logic [WIDTH-1:0] w_pc_next;
    logic [WIDTH-1:0] w_top;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_set_ovf;
    logic             w_set_unf;
    logic             w_set_ill;

    // Both adders wrap modulo 2^WIDTH; carries are dropped by truncation.
    // Branch offset is relative to the current pc, not the stepped one.
    assign w_pc_step   = r_pc + WIDTH'(STEP);
    assign w_pc_branch = r_pc + offset;

    ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_pc_step),
        .o_top   (w_top),
        .o_depth (depth),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Op decode: next pc, stack requests and fault strobes; stall holds all.
    always_comb begin
        w_pc_next = r_pc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_set_ovf = 1'b0;
        w_set_unf = 1'b0;
        w_set_ill = 1'b0;
        if (en && !rst) begin
            case (op)
                OP_INC:    w_pc_next = w_pc_step;
                OP_JUMP:   w_pc_next = target;
                OP_BRANCH: w_pc_next = w_pc_branch;
                OP_CALL: begin
                    if (w_full) begin
                        w_set_ovf = 1'b1;
                    end else begin
                        w_push    = 1'b1;
                        w_pc_next = target;
                    end
                end
                OP_RET: begin
                    if (w_empty) begin
                        w_set_unf = 1'b1;
                    end else begin
                        w_pop     = 1'b1;
                        w_pc_next = w_top;
                    end
                end
                default:   w_set_ill = !op_is_legal(op);
            endcase
        end
    end

    // Fetch address register and sticky fault flags; only reset clears faults.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= RESET_ADDR;
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
            r_err_ill <= 1'b0;
        end else if (en) begin
            r_pc      <= w_pc_next;
            r_err_ovf <= r_err_ovf | w_set_ovf;
            r_err_unf <= r_err_unf | w_set_unf;
            r_err_ill <= r_err_ill | w_set_ill;
        end
    end

    assign pc        = r_pc;
    assign ret_top   = w_top;
    assign stk_full  = w_full;
    assign stk_empty = w_empty;
    assign err_ovf   = r_err_ovf;
    assign err_unf   = r_err_unf;
    assign err_ill   = r_err_ill;

endmodule
